// File: rtl/wb_ram_bank_interface.sv
// Wishbone slave bridging single transfers onto NUM_BANKS synchronous RAM banks.
// Define WB_RAM_ERR_EN to answer unmapped addresses with wb_err_o instead of a dummy ack.
module wb_ram_bank_interface #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int RAM_ADDR_WIDTH = 11,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_BANKS      = 2,
    parameter int BANK_SEL_LSB   = 13,
    parameter int BANK_SEL_WIDTH = 4,
    parameter int RD_LATENCY     = 1
) (
    input  logic                            wb_clk_i,
    input  logic                            rst_i,
    input  logic                            wb_cyc_i,
    input  logic                            wb_stb_i,
    input  logic                            wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0]        wb_addr_i,
    input  logic [DATA_WIDTH/8-1:0]         wb_sel_i,
    input  logic [DATA_WIDTH-1:0]           wb_wdata_i,
    output logic [DATA_WIDTH-1:0]           wb_rdata_o,
    output logic                            wb_ack_o,
    output logic                            wb_err_o,
    output logic [NUM_BANKS-1:0]            ram_cs_o,
    output logic                            ram_we_o,
    output logic [DATA_WIDTH/8-1:0]         ram_be_o,
    output logic [RAM_ADDR_WIDTH-1:0]       ram_addr_o,
    output logic [DATA_WIDTH-1:0]           ram_wdata_o,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] ram_rdata_i
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W  = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0]          LAT_LOAD      = CNT_W'(RD_LATENCY);
    localparam logic [BANK_SEL_WIDTH:0]   NUM_BANKS_EXT = (BANK_SEL_WIDTH + 1)'(NUM_BANKS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        lat_cnt_reg;
    logic [BANK_W-1:0]       bank_reg;

    logic [BANK_SEL_WIDTH-1:0] bank_field;
    logic [BANK_W-1:0]         bank_idx;
    logic                      bank_mapped;
    logic [DATA_WIDTH-1:0]     bank_rdata [NUM_BANKS];
    logic                      unused_addr_bits;

    assign bank_field  = wb_addr_i[BANK_SEL_LSB +: BANK_SEL_WIDTH];
    assign bank_idx    = BANK_W'(bank_field);
    assign bank_mapped = ({1'b0, bank_field} < NUM_BANKS_EXT);

    // Only the word-address and bank-select fields matter; the rest is ignored.
    assign unused_addr_bits = ^wb_addr_i;

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_slice
            assign bank_rdata[gi] = ram_rdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

`ifdef WB_RAM_ERR_EN
    logic err_reg;
    assign wb_err_o = err_reg;
`else
    assign wb_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= '0;
            bank_reg    <= '0;
            wb_rdata_o  <= '0;
            wb_ack_o    <= 1'b0;
`ifdef WB_RAM_ERR_EN
            err_reg     <= 1'b0;
`endif
            ram_cs_o    <= '0;
            ram_we_o    <= 1'b0;
            ram_be_o    <= '0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
        end else begin
            // Strobes and responses are single-cycle pulses unless re-asserted below.
            ram_cs_o <= '0;
            ram_we_o <= 1'b0;
            ram_be_o <= '0;
            wb_ack_o <= 1'b0;
`ifdef WB_RAM_ERR_EN
            err_reg  <= 1'b0;
`endif
            unique case (state_reg)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        if (bank_mapped) begin
                            state_reg   <= ACCESS;
                            bank_reg    <= bank_idx;
                            ram_cs_o    <= NUM_BANKS'(1) << bank_idx;
                            ram_we_o    <= wb_we_i;
                            ram_be_o    <= wb_sel_i;
                            ram_addr_o  <= wb_addr_i[RAM_ADDR_WIDTH+1:2];
                            ram_wdata_o <= wb_wdata_i;
                        end else begin
                            state_reg <= RESP;
`ifdef WB_RAM_ERR_EN
                            err_reg   <= 1'b1;
`else
                            wb_ack_o  <= 1'b1;
                            if (!wb_we_i) begin
                                wb_rdata_o <= '0;
                            end
`endif
                        end
                    end
                end

                ACCESS: begin
                    // ram_we_o still reflects the access issued this cycle.
                    if (!wb_cyc_i) begin
                        state_reg <= IDLE;
                    end else if (ram_we_o) begin
                        state_reg <= RESP;
                        wb_ack_o  <= 1'b1;
                    end else begin
                        state_reg   <= WAIT;
                        lat_cnt_reg <= LAT_LOAD;
                    end
                end

                WAIT: begin
                    if (!wb_cyc_i) begin
                        state_reg   <= IDLE;
                        lat_cnt_reg <= '0;
                    end else if (lat_cnt_reg == CNT_W'(1)) begin
                        state_reg   <= RESP;
                        lat_cnt_reg <= '0;
                        wb_rdata_o  <= bank_rdata[bank_reg];
                        wb_ack_o    <= 1'b1;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - CNT_W'(1);
                    end
                end

                RESP: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_bank_interface.sv
// Randomized bench for wb_ram_bank_interface against a transaction-level memory model.
// Honours WB_RAM_ERR_EN when choosing the expected response to unmapped addresses.
module tb_wb_ram_bank_interface;

    localparam int NB     = 2;
    localparam int RD_LAT = 3;
    localparam int DW     = 32;
    localparam int RAW    = 11;
    localparam int WORDS  = 1 << RAW;

    logic            wb_clk_i = 1'b0;
    logic            rst_i    = 1'b1;
    logic            wb_cyc_i = 1'b0;
    logic            wb_stb_i = 1'b0;
    logic            wb_we_i  = 1'b0;
    logic [31:0]     wb_addr_i  = '0;
    logic [3:0]      wb_sel_i   = '0;
    logic [DW-1:0]   wb_wdata_i = '0;
    logic [DW-1:0]   wb_rdata_o;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic [NB-1:0]   ram_cs_o;
    logic            ram_we_o;
    logic [3:0]      ram_be_o;
    logic [RAW-1:0]  ram_addr_o;
    logic [DW-1:0]   ram_wdata_o;
    logic [NB*DW-1:0] ram_rdata_i;

    wb_ram_bank_interface #(
        .WB_ADDR_WIDTH (32),
        .RAM_ADDR_WIDTH(RAW),
        .DATA_WIDTH    (DW),
        .NUM_BANKS     (NB),
        .BANK_SEL_LSB  (13),
        .BANK_SEL_WIDTH(4),
        .RD_LATENCY    (RD_LAT)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .rst_i      (rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_sel_i   (wb_sel_i),
        .wb_wdata_i (wb_wdata_i),
        .wb_rdata_o (wb_rdata_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .ram_cs_o   (ram_cs_o),
        .ram_we_o   (ram_we_o),
        .ram_be_o   (ram_be_o),
        .ram_addr_o (ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Power-on content shared by the RAM model and the reference.
    function automatic logic [31:0] init_word(input int k, input int w);
        return 32'hA500_0000 ^ (32'(k) << 16) ^ (32'(w) * 32'h0101_0101);
    endfunction

    // ---------------- RAM bank model (registered read, RD_LAT-cycle pipe) ----------------
    logic [31:0] ram_mem  [NB][WORDS];
    bit          ram_wr_f [NB][WORDS];
    logic [31:0] rd_pipe  [NB][RD_LAT];
    logic [31:0] ram_cur;

    always @(posedge wb_clk_i) begin
        for (int k = 0; k < NB; k++) begin
            if (ram_cs_o[k]) begin
                ram_cur = ram_wr_f[k][ram_addr_o] ? ram_mem[k][ram_addr_o] : init_word(k, int'(ram_addr_o));
                if (ram_we_o) begin
                    for (int i = 0; i < 4; i++)
                        if (ram_be_o[i]) ram_cur[8*i +: 8] = ram_wdata_o[8*i +: 8];
                    ram_mem[k][ram_addr_o]  <= ram_cur;
                    ram_wr_f[k][ram_addr_o] <= 1'b1;
                end else begin
                    rd_pipe[k][0] <= ram_cur;
                end
            end
            for (int s = 1; s < RD_LAT; s++) rd_pipe[k][s] <= rd_pipe[k][s-1];
        end
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_rd
            assign ram_rdata_i[gi*DW +: DW] = rd_pipe[gi][RD_LAT-1];
        end
    endgenerate

    // ---------------- reference model and checking ----------------
    logic [31:0] ref_mem [NB][WORDS];
    logic [31:0] exp_rdata = '0;
    int n_checks = 0;
    int n_errors = 0;
    int txn_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (txn %0d, t=%0t)", tag, got, exp, txn_cnt, $time);
        end
    endtask

    task automatic ref_write(input int b, input int w, input logic [3:0] sel, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (sel[i]) ref_mem[b][w][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic drop_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    // Entered #1 after a rising edge with the DUT idle; that cycle is T.
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, input bit keep);
        int  b, w, lat, exp_lat;
        bit  mapped;
        logic [1:0] exp_resp;
        b      = int'(addr[16:13]);
        w      = int'(addr[12:2]);
        mapped = (b < NB);
        txn_cnt++;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_addr_i = addr; wb_sel_i = sel; wb_wdata_i = wdata;
        @(posedge wb_clk_i); #1;
        exp_resp = 2'b10;
        if (mapped) begin
            check("cs_pulse",  64'(ram_cs_o), 64'(1) << b);
            check("ram_we",    64'(ram_we_o), 64'(we));
            check("ram_be",    64'(ram_be_o), 64'(sel));
            check("ram_addr",  64'(ram_addr_o), 64'(w));
            check("ram_wdata", 64'(ram_wdata_o), 64'(wdata));
            check("early_resp", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
            exp_lat = we ? 2 : 2 + RD_LAT;
            if (we) ref_write(b, w, sel, wdata);
            else    exp_rdata = ref_mem[b][w];
        end else begin
            check("cs_unmapped", {57'd0, ram_cs_o, ram_we_o, ram_be_o}, 64'd0);
            exp_lat = 1;
`ifdef WB_RAM_ERR_EN
            exp_resp = 2'b01;
`else
            if (!we) exp_rdata = '0;
`endif
        end
        lat = 1;
        while (!(wb_ack_o || wb_err_o) && lat < 12) begin
            @(posedge wb_clk_i); #1;
            lat++;
            check("cs_quiet", {57'd0, ram_cs_o, ram_we_o, ram_be_o}, 64'd0);
        end
        check("latency",  64'(lat), 64'(exp_lat));
        check("ack_err",  {62'd0, wb_ack_o, wb_err_o}, {62'd0, exp_resp});
        check("rdata",    64'(wb_rdata_o), 64'(exp_rdata));
        $display("TXN %0d we=%0d addr=%08h sel=%h wdata=%08h lat=%0d ack=%0d err=%0d rdata=%08h",
                 txn_cnt, we, addr, sel, wdata, lat, wb_ack_o, wb_err_o, wb_rdata_o);
        if (!keep) drop_bus();
        @(posedge wb_clk_i); #1;
        check("resp_single", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
        check("cs_after",    64'(ram_cs_o), 64'd0);
    endtask

    task automatic quiet_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge wb_clk_i); #1;
            check(tag, {62'd0, wb_ack_o, wb_err_o}, 64'd0);
        end
    endtask

    logic [31:0] r_addr, r_data, r_rand;
    int          r_b, r_w;

    initial begin
        for (int k = 0; k < NB; k++)
            for (int w = 0; w < WORDS; w++) ref_mem[k][w] = init_word(k, w);

        // Reset state
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("reset_outputs",
              {wb_rdata_o, wb_ack_o, wb_err_o, ram_cs_o, ram_we_o, ram_be_o, ram_addr_o[10:0], 11'd0},
              64'd0);
        check("reset_wdata", 64'(ram_wdata_o), 64'd0);
        rst_i = 1'b0;

        // First request in the first cycle out of reset; canonical write to bank 1.
        do_txn(1'b1, 32'h0000_2008, 4'hF, 32'hDEAD_BEEF, 1'b0);
        do_txn(1'b0, 32'h0000_2008, 4'hF, 32'h0, 1'b0);
        // Bank 0 read with RD_LATENCY=3 -> ack in T+5.
        do_txn(1'b1, 32'h0000_0004, 4'hF, 32'h1234_5678, 1'b0);
        do_txn(1'b0, 32'h0000_0004, 4'h0, 32'h0, 1'b0);
        // Unmapped bank 5, read then write.
        do_txn(1'b0, 32'h0000_A000, 4'hF, 32'h0, 1'b0);
        do_txn(1'b1, 32'h0000_A000, 4'hF, 32'hFFFF_FFFF, 1'b0);
        // Zero byte-select write still pulses cs and acks; data unchanged.
        do_txn(1'b1, 32'h0000_0004, 4'h0, 32'hCAFE_F00D, 1'b0);
        do_txn(1'b0, 32'h0000_0004, 4'hF, 32'h0, 1'b0);
        // Partial byte write at top word of bank 1.
        do_txn(1'b1, 32'h0000_3FFC, 4'h5, 32'h1122_3344, 1'b0);
        do_txn(1'b0, 32'h0000_3FFC, 4'hF, 32'h0, 1'b0);
        // Back-to-back with strobe held across the ack.
        do_txn(1'b1, 32'h0000_0010, 4'hF, 32'hA0A0_0001, 1'b1);
        do_txn(1'b1, 32'h0000_0010, 4'hF, 32'hA0A0_0001, 1'b1);
        do_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b1);
        do_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b0);

        // cyc dropped in WAIT: no response, then a normal transfer succeeds.
        txn_cnt++;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 32'h0000_2020; wb_sel_i = 4'hF;
        @(posedge wb_clk_i); #1;
        @(posedge wb_clk_i); #1;
        drop_bus();
        quiet_cycles(RD_LAT + 3, "abort_wait_noack");
        $display("TXN %0d read aborted in WAIT", txn_cnt);
        do_txn(1'b0, 32'h0000_0004, 4'hF, 32'h0, 1'b0);

        // cyc dropped in ACCESS on a write: no ack, but the write lands.
        txn_cnt++;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_addr_i = 32'h0000_0040;
        wb_sel_i = 4'hF; wb_wdata_i = 32'h5A5A_1234;
        @(posedge wb_clk_i); #1;
        check("abort_write_cs", 64'(ram_cs_o), 64'd1);
        ref_write(0, 16, 4'hF, 32'h5A5A_1234);
        drop_bus();
        quiet_cycles(3, "abort_access_noack");
        $display("TXN %0d write aborted in ACCESS", txn_cnt);
        do_txn(1'b0, 32'h0000_0040, 4'hF, 32'h0, 1'b0);

        // Reset pulsed during ACCESS of a read.
        txn_cnt++;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 32'h0000_2014; wb_sel_i = 4'hF;
        @(posedge wb_clk_i); #1;
        check("pre_reset_cs", 64'(ram_cs_o), 64'd2);
        rst_i = 1'b1;
        drop_bus();
        #1;
        check("reset_mid_outputs",
              {wb_rdata_o, wb_ack_o, wb_err_o, ram_cs_o, ram_we_o, ram_be_o, ram_addr_o[10:0], 11'd0},
              64'd0);
        exp_rdata = '0;
        @(posedge wb_clk_i); #1;
        rst_i = 1'b0;
        quiet_cycles(RD_LAT + 3, "reset_mid_noack");
        $display("TXN %0d read aborted by reset", txn_cnt);
        do_txn(1'b0, 32'h0000_2014, 4'hF, 32'h0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            r_rand = $urandom();
            r_data = $urandom();
            r_b = ($urandom_range(0, 7) == 0) ? int'($urandom_range(NB, 15)) : int'($urandom_range(0, NB - 1));
            r_w = ($urandom_range(0, 3) == 0) ? WORDS - 1 : int'($urandom_range(0, 15));
            r_addr = (r_rand & 32'hFFFE_0000) | (32'(r_b) << 13) | (32'(r_w) << 2) | (r_rand & 32'h3);
            do_txn(1'($urandom_range(0, 1)), r_addr, 4'($urandom_range(0, 15)), r_data,
                   1'($urandom_range(0, 3) == 0));
        end
        drop_bus();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
